// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with a dark gap between digits,
// double-buffered digit data committed on frame wrap, and leading-zero blanking.
module seg7_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        LOAD,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        LZ_BLANK,
    output logic [3:0]  BINARY_OUT,
    output logic [1:0]  SEGMENT_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        LOAD_ACK
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] presc_r, presc_s;
    logic [1:0]    idx_r, idx_s;
    logic [15:0]   act_digits_r, act_digits_s;
    logic [3:0]    act_dots_r, act_dots_s;
    logic [15:0]   pend_digits_r, pend_digits_s;
    logic [3:0]    pend_dots_r, pend_dots_s;
    logic          pend_r, pend_s;
    logic          commit_s;
    logic [3:0]    binary_s;
    logic          dot_s;
    logic          blank_s;

    // A digit is suppressed only if it and every more significant digit is a dot-less zero.
    function automatic logic lz_suppress(input logic [15:0] digits, input logic [3:0] dots,
                                         input logic [1:0] idx, input logic lz);
        logic zero_above;
        zero_above = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (k >= int'(idx)) begin
                zero_above = zero_above & (digits[4*k +: 4] == 4'd0) & ~dots[k];
            end else begin
                zero_above = zero_above;
            end
        end
        return lz & (idx != 2'd0) & zero_above;
    endfunction

    // Next-state, buffer commit and output value computation.
    always_comb begin
        state_s  = state_r;
        presc_s  = presc_r;
        idx_s    = idx_r;
        commit_s = 1'b0;
        if (!ENABLE) begin
            state_s  = IDLE;
            presc_s  = {CW{1'b0}};
            idx_s    = 2'd0;
            commit_s = pend_r & (state_r == IDLE);
        end else begin
            case (state_r)
                IDLE: begin
                    state_s  = SHOW;
                    presc_s  = {CW{1'b0}};
                    idx_s    = 2'd0;
                    commit_s = pend_r;
                end
                SHOW: begin
                    if (presc_r == SHOW_LAST) begin
                        presc_s  = {CW{1'b0}};
                        idx_s    = idx_r + 2'd1;
                        commit_s = pend_r & (idx_r == 2'd3);
                        if (BLANK_CYCLES > 0) begin
                            state_s = GAP;
                        end else begin
                            state_s = SHOW;
                        end
                    end else begin
                        presc_s = presc_r + CW'(1);
                    end
                end
                GAP: begin
                    if (presc_r == GAP_LAST) begin
                        presc_s = {CW{1'b0}};
                        state_s = SHOW;
                    end else begin
                        presc_s = presc_r + CW'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    presc_s = {CW{1'b0}};
                    idx_s   = 2'd0;
                end
            endcase
        end

        // The commit uses the pending data as it stood before any same-cycle LOAD.
        act_digits_s  = commit_s ? pend_digits_r : act_digits_r;
        act_dots_s    = commit_s ? pend_dots_r : act_dots_r;
        pend_digits_s = LOAD ? DIGITS_IN : pend_digits_r;
        pend_dots_s   = LOAD ? DOTS_IN : pend_dots_r;
        pend_s        = LOAD | (pend_r & ~commit_s);

        binary_s = act_digits_s[{idx_s, 2'b00} +: 4];
        dot_s    = act_dots_s[idx_s];
        blank_s  = (state_s != SHOW) | lz_suppress(act_digits_s, act_dots_s, idx_s, LZ_BLANK);
    end

    // State, buffers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= IDLE;
            presc_r       <= {CW{1'b0}};
            idx_r         <= 2'd0;
            act_digits_r  <= 16'd0;
            act_dots_r    <= 4'd0;
            pend_digits_r <= 16'd0;
            pend_dots_r   <= 4'd0;
            pend_r        <= 1'b0;
            BINARY_OUT    <= 4'd0;
            SEGMENT_OUT   <= 2'd0;
            DOT_OUT       <= 1'b0;
            BLANK_OUT     <= 1'b1;
            LOAD_ACK      <= 1'b0;
        end else begin
            state_r       <= state_s;
            presc_r       <= presc_s;
            idx_r         <= idx_s;
            act_digits_r  <= act_digits_s;
            act_dots_r    <= act_dots_s;
            pend_digits_r <= pend_digits_s;
            pend_dots_r   <= pend_dots_s;
            pend_r        <= pend_s;
            BINARY_OUT    <= binary_s;
            SEGMENT_OUT   <= idx_s;
            DOT_OUT       <= dot_s;
            BLANK_OUT     <= blank_s;
            LOAD_ACK      <= commit_s;
        end
    end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: each task queues expected outputs keyed
// by cycle number and compares them as the run reaches each cycle.
module tb_seg7_scan_controller;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] DIGITS_IN = 16'h0000;
    logic [3:0]  DOTS_IN = 4'h0;
    logic        LZ_BLANK = 1'b0;
    logic [3:0]  BINARY_OUT, bin_ng;
    logic [1:0]  SEGMENT_OUT, seg_ng;
    logic        DOT_OUT, dot_ng, BLANK_OUT, blank_ng, LOAD_ACK, ack_ng;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int         t;
        logic [1:0] seg;
        logic [3:0] bin;
        logic       dot;
        logic       blank;
        logic       ack;
        logic       care;
    } exp_t;
    exp_t exp_q[$];

    seg7_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD),
        .DIGITS_IN(DIGITS_IN), .DOTS_IN(DOTS_IN), .LZ_BLANK(LZ_BLANK),
        .BINARY_OUT(BINARY_OUT), .SEGMENT_OUT(SEGMENT_OUT), .DOT_OUT(DOT_OUT),
        .BLANK_OUT(BLANK_OUT), .LOAD_ACK(LOAD_ACK)
    );

    seg7_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_ng (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD),
        .DIGITS_IN(DIGITS_IN), .DOTS_IN(DOTS_IN), .LZ_BLANK(LZ_BLANK),
        .BINARY_OUT(bin_ng), .SEGMENT_OUT(seg_ng), .DOT_OUT(dot_ng),
        .BLANK_OUT(blank_ng), .LOAD_ACK(ack_ng)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        ENABLE = 1'b0;
        LOAD = 1'b0;
        tick();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    task automatic expect_at(input int t, input logic [1:0] seg, input logic [3:0] bin,
                             input logic dot, input logic blank, input logic ack, input logic care);
        exp_t e;
        e.t = t; e.seg = seg; e.bin = bin; e.dot = dot;
        e.blank = blank; e.ack = ack; e.care = care;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        exp_q.delete();
        RESET = 1'b1; ENABLE = 1'b1; LOAD = 1'b1; DIGITS_IN = 16'hFFFF; DOTS_IN = 4'hF; LZ_BLANK = 1'b0;
        for (int t = 1; t <= 4; t++) expect_at(t, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL reset t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 2) begin RESET = 1'b0; ENABLE = 1'b0; LOAD = 1'b0; end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b0;
        ENABLE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) expect_at(6*k + c + 1, 2'(k % 4), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k < 4) for (int c = 0; c < 2; c++) expect_at(6*k + 5 + c, 2'((k + 1) % 4), 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        for (int t = 1; t <= 28; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL scan t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_no_gap();
        exp_t e;
        do_reset();
        ENABLE = 1'b1;
        for (int t = 1; t <= 16; t++) expect_at(t, 2'(((t - 1) / 4) % 4), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 16; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (seg_ng !== e.seg || blank_ng !== e.blank || ack_ng !== e.ack ||
                    (e.care && (bin_ng !== e.bin || dot_ng !== e.dot)))
                    $display("FAIL no_gap t=%0d got seg=%0d bin=%h blank=%b ack=%b exp seg=%0d bin=%h blank=%b ack=%b",
                             t, seg_ng, bin_ng, blank_ng, ack_ng, e.seg, e.bin, e.blank, e.ack);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_idle_load();
        exp_t e;
        logic [15:0] dv;
        logic [3:0]  pv;
        do_reset();
        dv = 16'h1234; pv = 4'b0100;
        LZ_BLANK = 1'b0; LOAD = 1'b1; DIGITS_IN = dv; DOTS_IN = pv;
        expect_at(1, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(2, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_at(3, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) expect_at(4 + 6*k, 2'(k), dv[4*k +: 4], pv[k], 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 22; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL idle_load t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 1) LOAD = 1'b0;
            if (t == 3) ENABLE = 1'b1;
        end
    endtask

    task automatic test_scan_load();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b0; LOAD = 1'b1; DIGITS_IN = 16'h1234; DOTS_IN = 4'b0000;
        expect_at(2,  2'd0, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_at(11, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(15, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(21, 2'd3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(25, 2'd0, 4'hD, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(26, 2'd0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(27, 2'd0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(33, 2'd1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 33; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL scan_load t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 1) LOAD = 1'b0;
            if (t == 2) ENABLE = 1'b1;
            if (t == 9) begin LOAD = 1'b1; DIGITS_IN = 16'hABCD; end
            if (t == 10) LOAD = 1'b0;
        end
    endtask

    task automatic test_lz();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b1; LOAD = 1'b1; DIGITS_IN = 16'h0050; DOTS_IN = 4'b0000;
        expect_at(3,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(9,  2'd1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(15, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(21, 2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(24, 2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(25, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(26, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_at(27, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(33, 2'd1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(39, 2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(45, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 45; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL lz_blank t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 1) LOAD = 1'b0;
            if (t == 2) ENABLE = 1'b1;
            if (t == 24) begin ENABLE = 1'b0; LOAD = 1'b1; DOTS_IN = 4'b1000; end
            if (t == 25) LOAD = 1'b0;
            if (t == 26) ENABLE = 1'b1;
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b0;
        ENABLE = 1'b1;
        expect_at(11, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(12, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(13, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(14, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(17, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(18, 2'd1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int t = 1; t <= 18; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL enable_drop t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 11) ENABLE = 1'b0;
            if (t == 13) ENABLE = 1'b1;
        end
    endtask

    task automatic test_load_wrap();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b0; DOTS_IN = 4'b0000;
        ENABLE = 1'b1;
        expect_at(23, 2'd0, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(24, 2'd0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(31, 2'd1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(47, 2'd0, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_at(48, 2'd0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(71, 2'd0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(95, 2'd0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int t = 1; t <= 95; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL load_wrap t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            LOAD = (t == 10) || (t == 22) || (t == 70);
            if (t == 10) DIGITS_IN = 16'h5678;
            if (t == 22) DIGITS_IN = 16'h9ABC;
            if (t == 70) DIGITS_IN = 16'hDEF1;
        end
    endtask

    task automatic test_reset_discard();
        exp_t e;
        do_reset();
        LZ_BLANK = 1'b0; DOTS_IN = 4'b0000;
        ENABLE = 1'b1;
        expect_at(6,  2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(7,  2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(8,  2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(9,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(31, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int t = 1; t <= 31; t++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].t == t) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (SEGMENT_OUT !== e.seg || BLANK_OUT !== e.blank || LOAD_ACK !== e.ack ||
                    (e.care && (BINARY_OUT !== e.bin || DOT_OUT !== e.dot)))
                    $display("FAIL reset_discard t=%0d got seg=%0d bin=%h dot=%b blank=%b ack=%b exp seg=%0d bin=%h dot=%b blank=%b ack=%b",
                             t, SEGMENT_OUT, BINARY_OUT, DOT_OUT, BLANK_OUT, LOAD_ACK, e.seg, e.bin, e.dot, e.blank, e.ack);
                else
                    pass_cnt++;
            end
            if (t == 2) begin LOAD = 1'b1; DIGITS_IN = 16'h1234; end
            if (t == 3) LOAD = 1'b0;
            if (t == 5) RESET = 1'b1;
            if (t == 6) begin RESET = 1'b0; ENABLE = 1'b0; end
            if (t == 8) ENABLE = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_gap();
        test_idle_load();
        test_scan_load();
        test_lz();
        test_enable_drop();
        test_load_wrap();
        test_reset_discard();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
